// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its code decoder.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Active-low one-cold drive pattern, indexed by column number.
    localparam logic [NUM_COLS-1:0] COL_DRIVE [NUM_COLS] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Maps a (row, column) keypad position to its hex key code; '*' is E and '#' is F.
module keypad_decoder (
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] code
);

    always_comb begin
        code = 4'h0;
        unique case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 keypad: drives one column at a time, debounces
// press and release on the latched row, and pulses key_valid once per press.
//
// state    | meaning
// SCAN     | dwell on current column, sample rows on the last dwell cycle
// DEBOUNCE | column frozen, counting consecutive low cycles on latched row
// HELD     | key accepted, waiting for the latched row to go high
// RELEASE  | counting consecutive high cycles before resuming the scan
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows_sync,
    output logic [NUM_COLS-1:0] cols,
    output logic [3:0]          key,
    output logic                key_valid
);

    localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          row_q, row_d;
    logic [NUM_COLS-1:0] cols_q, cols_d;
    logic [3:0]          key_q, key_d;
    logic                key_valid_q, key_valid_d;
    logic [3:0]          code;
    logic                row_high;

    keypad_decoder u_decoder (
        .row  (row_q),
        .col  (col_q),
        .code (code)
    );

    assign row_high = rows_sync[row_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        key_d       = key_q;
        key_valid_d = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    // Rows are only trusted once the synchronizer has caught up with this column.
                    if (rows_sync != '1) begin
                        row_d   = first_low_row(rows_sync);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_high) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    key_d       = code;
                    key_valid_d = 1'b1;
                    state_d     = HELD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (row_high) state_d = RELEASE;
            end
            RELEASE: begin
                if (!row_high) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        cols_d = COL_DRIVE[col_d];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cols_q      <= COL_DRIVE[0];
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cols_q      <= cols_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model plus a two-flop row delay.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows_sync;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;

    logic [3:0] rows_raw;
    logic [3:0] sync1;
    logic       key_down [4][4];
    logic [3:0] drive_tbl [4];

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] exp_key;
        logic [3:0] exp_cols_held;
        logic [3:0] exp_cols_next;
    } vec_t;

    vec_t vecs [16];

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows_sync (rows_sync),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows_raw = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r][c] && !cols[c]) rows_raw[r] = 1'b0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 4'b1111;
            rows_sync <= 4'b1111;
        end else begin
            sync1     <= rows_raw;
            rows_sync <= sync1;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1) pulse_cnt++;
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) seen = 1'b1;
        end
        check_int({name, "_pulse_seen"}, int'(seen), 1);
    endtask

    task automatic wait_col_entry(input string name, input logic [3:0] target);
        bit         ok;
        logic [3:0] prev;
        ok   = 1'b0;
        prev = cols;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cols == target && prev != target) ok = 1'b1;
            prev = cols;
        end
        check_int({name, "_col_entry"}, int'(ok), 1);
    endtask

    task automatic set_key(input int r, input int c, input logic down);
        key_down[r][c] = down;
    endtask

    initial begin
        int base;
        drive_tbl[0] = 4'b1110;
        drive_tbl[1] = 4'b1101;
        drive_tbl[2] = 4'b1011;
        drive_tbl[3] = 4'b0111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                key_down[r][c] = 1'b0;

        vecs[0]  = '{0, 0, 4'h1, 4'b1110, 4'b1101};
        vecs[1]  = '{0, 1, 4'h2, 4'b1101, 4'b1011};
        vecs[2]  = '{0, 2, 4'h3, 4'b1011, 4'b0111};
        vecs[3]  = '{0, 3, 4'hA, 4'b0111, 4'b1110};
        vecs[4]  = '{1, 0, 4'h4, 4'b1110, 4'b1101};
        vecs[5]  = '{1, 1, 4'h5, 4'b1101, 4'b1011};
        vecs[6]  = '{1, 2, 4'h6, 4'b1011, 4'b0111};
        vecs[7]  = '{1, 3, 4'hB, 4'b0111, 4'b1110};
        vecs[8]  = '{2, 0, 4'h7, 4'b1110, 4'b1101};
        vecs[9]  = '{2, 1, 4'h8, 4'b1101, 4'b1011};
        vecs[10] = '{2, 2, 4'h9, 4'b1011, 4'b0111};
        vecs[11] = '{2, 3, 4'hC, 4'b0111, 4'b1110};
        vecs[12] = '{3, 0, 4'hE, 4'b1110, 4'b1101};
        vecs[13] = '{3, 1, 4'h0, 4'b1101, 4'b1011};
        vecs[14] = '{3, 2, 4'hF, 4'b1011, 4'b0111};
        vecs[15] = '{3, 3, 4'hD, 4'b0111, 4'b1110};

        // Reset values
        reset = 1'b0;
        #12;
        check4("rst_cols", cols, 4'b1110);
        check4("rst_key", key, 4'h0);
        check4("rst_key_valid", {3'b0, key_valid}, 4'h0);

        // Idle scan: column index advances every 4 cycles after release
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check4($sformatf("idle_cols_k%0d", k), cols, drive_tbl[(k / 4) % 4]);
        end
        check_int("idle_no_pulse", pulse_cnt, 0);
        check4("idle_key", key, 4'h0);

        // Full key map: press, hold, release for each position
        for (int v = 0; v < 16; v++) begin
            base = pulse_cnt;
            set_key(vecs[v].row, vecs[v].col, 1'b1);
            wait_pulse($sformatf("map%0d", v));
            check4($sformatf("map%0d_key", v), key, vecs[v].exp_key);
            repeat (10) @(negedge clk);
            check4($sformatf("map%0d_cols_held", v), cols, vecs[v].exp_cols_held);
            check_int($sformatf("map%0d_pulses", v), pulse_cnt, base + 1);
            set_key(vecs[v].row, vecs[v].col, 1'b0);
            repeat (12) @(negedge clk);
            check4($sformatf("map%0d_cols_next", v), cols, vecs[v].exp_cols_next);
        end

        // Long hold of key 6 (row 1, column 2)
        base = pulse_cnt;
        set_key(1, 2, 1'b1);
        wait_pulse("hold6");
        check4("hold6_key", key, 4'h6);
        repeat (40) @(negedge clk);
        check4("hold6_cols", cols, 4'b1011);
        check_int("hold6_pulses", pulse_cnt, base + 1);
        set_key(1, 2, 1'b0);
        repeat (12) @(negedge clk);
        check4("hold6_resume", cols, 4'b0111);

        // Press bounce on row 0 / column 0: no pulse, rescan stays on column 0
        base = pulse_cnt;
        wait_col_entry("bounce", 4'b1110);
        set_key(0, 0, 1'b1);
        repeat (6) @(negedge clk);
        set_key(0, 0, 1'b0);
        repeat (4) @(negedge clk);
        check4("bounce_cols_col0", cols, 4'b1110);
        repeat (20) @(negedge clk);
        check_int("bounce_no_pulse", pulse_cnt, base);
        check4("bounce_key_kept", key, 4'h6);

        // Release glitch during HELD on key 0 (row 3, column 1)
        base = pulse_cnt;
        set_key(3, 1, 1'b1);
        wait_pulse("glitch");
        check4("glitch_key", key, 4'h0);
        repeat (5) @(negedge clk);
        set_key(3, 1, 1'b0);
        repeat (2) @(negedge clk);
        set_key(3, 1, 1'b1);
        repeat (12) @(negedge clk);
        check_int("glitch_pulses", pulse_cnt, base + 1);
        check4("glitch_cols_frozen", cols, 4'b1101);
        set_key(3, 1, 1'b0);
        repeat (12) @(negedge clk);
        check4("glitch_resume", cols, 4'b1011);

        // Two rows low on column 3: row 2 wins
        base = pulse_cnt;
        set_key(2, 3, 1'b1);
        set_key(3, 3, 1'b1);
        wait_pulse("multi");
        check4("multi_key", key, 4'hC);
        repeat (10) @(negedge clk);
        check_int("multi_pulses", pulse_cnt, base + 1);
        set_key(2, 3, 1'b0);
        set_key(3, 3, 1'b0);
        repeat (12) @(negedge clk);
        check4("multi_resume", cols, 4'b1110);

        // Reset during DEBOUNCE on column 2
        wait_col_entry("rst_deb", 4'b1011);
        set_key(0, 2, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check4("rst_deb_cols", cols, 4'b1110);
        check4("rst_deb_key", key, 4'h0);
        check4("rst_deb_key_valid", {3'b0, key_valid}, 4'h0);
        set_key(0, 2, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check4("rst_deb_restart_c0", cols, 4'b1110);
        @(negedge clk);
        check4("rst_deb_restart_c1", cols, 4'b1101);

        // Reset during the key_valid pulse of key 5
        set_key(1, 1, 1'b1);
        wait_pulse("rst_pulse");
        check4("rst_pulse_key_before", key, 4'h5);
        reset = 1'b0;
        #1;
        check4("rst_pulse_key_valid", {3'b0, key_valid}, 4'h0);
        check4("rst_pulse_key", key, 4'h0);
        check4("rst_pulse_cols", cols, 4'b1110);
        set_key(1, 1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        base = pulse_cnt;
        repeat (3) @(negedge clk);
        check4("rst_pulse_restart_c0", cols, 4'b1110);
        @(negedge clk);
        check4("rst_pulse_restart_c1", cols, 4'b1101);
        repeat (30) @(negedge clk);
        check_int("final_no_pulse", pulse_cnt, base);
        check4("final_key", key, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
